// File: rtl/uart_receiver.sv
// UART receive framer: synchronizes rx_i, samples 5-8 data bits plus optional parity and 1-2 stop bits.
// Optional UART_RX_MAJORITY_EN: each bit decision is a 2-of-3 vote over the last three ticks.
module uart_receiver #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       rx_i,
    input  logic [1:0] data_bit_num_i,
    input  logic       parity_en_i,
    input  logic       parity_type_i,
    input  logic       stop_bit_num_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] START_DEC = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_DEC   = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   bit_c;
    logic [CNT_W-1:0]       cnt;
    logic [7:0]             shreg;
    logic [2:0]             bit_idx;
    logic                   stop_idx;
    logic                   perr;
    logic                   ferr;
    logic                   armed;
    logic [1:0]             dbits_q;
    logic                   pen_q;
    logic                   ptype_q;
    logic                   stop2_q;
    logic [2:0]             last_idx_c;
    logic                   par_exp_c;

    // Input synchronizer; idles high
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // rx_s from the previous two ticks, feeding the 2-of-3 vote
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist <= 2'b11;
        end else if (tick_i) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign bit_c = (hist[0] & hist[1]) | (hist[0] & rx_s) | (hist[1] & rx_s);
`else
    assign bit_c = rx_s;
`endif

    assign last_idx_c = 3'(4) + 3'(dbits_q);
    assign par_exp_c  = ptype_q ? (^shreg) : ~(^shreg);

    // Frame FSM; shreg is cleared at START so unused upper bits read as zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            armed        <= 1'b1;
            dbits_q      <= '0;
            pen_q        <= 1'b0;
            ptype_q      <= 1'b0;
            stop2_q      <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            if (tick_i) begin
                cnt <= cnt + CNT_W'(1);
                case (state)
                    IDLE: begin
                        // After a low final stop (e.g. break) wait for the line to go high
                        if (rx_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state   <= START;
                            cnt     <= '0;
                            shreg   <= '0;
                            perr    <= 1'b0;
                            ferr    <= 1'b0;
                            busy_o  <= 1'b1;
                            dbits_q <= data_bit_num_i;
                            pen_q   <= parity_en_i;
                            ptype_q <= parity_type_i;
                            stop2_q <= stop_bit_num_i;
                        end
                    end
                    START: begin
                        if (cnt == START_DEC) begin
                            if (bit_c) begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end else begin
                                state   <= DATA;
                                cnt     <= '0;
                                bit_idx <= '0;
                            end
                        end
                    end
                    DATA: begin
                        if (cnt == BIT_DEC) begin
                            shreg[bit_idx] <= bit_c;
                            bit_idx        <= bit_idx + 3'(1);
                            stop_idx       <= 1'b0;
                            if (bit_idx == last_idx_c) begin
                                state <= pen_q ? PARITY : STOP;
                            end
                        end
                    end
                    PARITY: begin
                        if (cnt == BIT_DEC) begin
                            perr  <= (bit_c != par_exp_c);
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (cnt == BIT_DEC) begin
                            if (stop2_q && !stop_idx) begin
                                stop_idx <= 1'b1;
                                ferr     <= ferr | ~bit_c;
                            end else begin
                                state        <= IDLE;
                                busy_o       <= 1'b0;
                                armed        <= bit_c;
                                data_valid_o <= 1'b1;
                                data_o       <= shreg;
                                parity_err_o <= perr;
                                frame_err_o  <= ferr | ~bit_c;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level model (expected characters queued from the bits sent)
// with a per-cycle compare process, plus directed and random frames.
module tb_uart_receiver;

    localparam int unsigned OS       = 16;
    localparam int unsigned TICK_DIV = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] dbits = 2'd3;
    logic       pen = 1'b0;
    logic       ptype = 1'b0;
    logic       stop2 = 1'b0;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       busy_o;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t        q[$];
    exp_t        last = '0;
    int          compared = 0;
    int          mismatched = 0;
    int unsigned div = 0;

    uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tick_i         (tick),
        .rx_i           (rx),
        .data_bit_num_i (dbits),
        .parity_en_i    (pen),
        .parity_type_i  (ptype),
        .stop_bit_num_i (stop2),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .parity_err_o   (parity_err_o),
        .frame_err_o    (frame_err_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // Baud tick: one clock wide, every TICK_DIV clocks
    always @(negedge clk) begin
        tick = (div == TICK_DIV - 1);
        div  = (div == TICK_DIV - 1) ? 0 : div + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: outputs must hold the most recently completed frame; each pulse consumes one expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid_o) begin
                if (q.size() == 0) begin
                    check("valid_without_frame", 32'(data_valid_o), 0);
                end else begin
                    last = q.pop_front();
                    check("busy_at_valid", 32'(busy_o), 0);
                end
            end
            check("data_o", 32'(data_o), 32'(last.data));
            check("parity_err_o", 32'(parity_err_o), 32'(last.perr));
            check("frame_err_o", 32'(frame_err_o), 32'(last.ferr));
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx = b;
        wait_ticks(OS);
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk);
        rx = 1'b1;
        if (n > 0) wait_ticks(n * OS);
    endtask

    task automatic check_reset_values();
        check("rst_data", 32'(data_o), 0);
        check("rst_valid", 32'(data_valid_o), 0);
        check("rst_perr", 32'(parity_err_o), 0);
        check("rst_ferr", 32'(frame_err_o), 0);
        check("rst_busy", 32'(busy_o), 0);
    endtask

    task automatic mid_frame_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        last = '0;
        #1;
        check_reset_values();
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(2 * OS);
    endtask

    // Drive one frame and queue its expected result; abort_bit >= 0 resets the DUT during that data bit
    task automatic send_frame(input logic [7:0] d, input int n, input logic p_en, input logic p_type,
                              input logic s2, input logic flip, input logic s1_low, input logic s2_low,
                              input int abort_bit);
        logic [7:0] m;
        logic       pb;
        exp_t       e;
        m      = d & 8'((1 << n) - 1);
        pb     = (p_type ? (^m) : ~(^m)) ^ flip;
        e.data = m;
        e.perr = p_en & flip;
        e.ferr = s1_low | (s2 & s2_low);
        @(negedge clk);
        dbits = 2'(n - 5);
        pen   = p_en;
        ptype = p_type;
        stop2 = s2;
        if (abort_bit < 0) q.push_back(e);
        drive_bit(1'b0);
        #1;
        check("busy_mid_frame", 32'(busy_o), 1);
        dbits = 2'($urandom);
        pen   = 1'($urandom);
        ptype = 1'($urandom);
        stop2 = 1'($urandom);
        for (int j = 0; j < n; j++) begin
            if (j == abort_bit) begin
                @(negedge clk);
                rx = m[j];
                wait_ticks(OS / 2);
                mid_frame_reset();
                return;
            end
            drive_bit(m[j]);
        end
        if (p_en) drive_bit(pb);
        drive_bit(!s1_low);
        if (s2) drive_bit(!s2_low);
        check("frame_drained", 32'(q.size()), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        idle_bits(2);

        // 8N1 0xA5
        send_frame(8'hA5, 8, 0, 0, 0, 0, 0, 0, -1);
        check("a5_data", 32'(data_o), 32'h0A5);
        check("a5_perr", 32'(parity_err_o), 0);
        check("a5_ferr", 32'(frame_err_o), 0);
        check("a5_busy", 32'(busy_o), 0);

        // 7 bits, parity_type=0, correct then inverted parity bit
        send_frame(8'h35, 7, 1, 0, 0, 0, 0, 0, -1);
        check("p35_data", 32'(data_o), 32'h35);
        check("p35_perr", 32'(parity_err_o), 0);
        send_frame(8'h35, 7, 1, 0, 0, 1, 0, 0, -1);
        check("p35bad_data", 32'(data_o), 32'h35);
        check("p35bad_perr", 32'(parity_err_o), 1);

        // 5 bits, 2 stop bits, second stop low
        send_frame(8'h1F, 5, 0, 0, 1, 0, 0, 1, -1);
        check("s1f_data", 32'(data_o), 32'h1F);
        check("s1f_ferr", 32'(frame_err_o), 1);
        idle_bits(1);

        // 3-tick start glitch: no frame
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(3);
        idle_bits(2);
        check("glitch_busy", 32'(busy_o), 0);
        check("glitch_data_held", 32'(data_o), 32'h1F);

`ifdef UART_RX_MAJORITY_EN
        // 0x00 8N1 with a one-tick high glitch at the data bit 2 decision tick
        begin
            exp_t e;
            e = '0;
            @(negedge clk);
            dbits = 2'd3; pen = 1'b0; ptype = 1'b0; stop2 = 1'b0;
            q.push_back(e);
            drive_bit(1'b0);
            drive_bit(1'b0);
            drive_bit(1'b0);
            @(negedge clk); rx = 1'b0; wait_ticks(8);
            @(negedge clk); rx = 1'b1; wait_ticks(1);
            @(negedge clk); rx = 1'b0; wait_ticks(OS - 9);
            for (int j = 3; j < 8; j++) drive_bit(1'b0);
            drive_bit(1'b1);
            check("maj_data", 32'(data_o), 0);
            check("maj_drained", 32'(q.size()), 0);
        end
`endif

        // Reset during data bit 4, then a clean 0x3C
        send_frame(8'hC3, 8, 0, 0, 0, 0, 0, 0, 4);
        send_frame(8'h3C, 8, 0, 0, 0, 0, 0, 0, -1);
        check("r3c_data", 32'(data_o), 32'h3C);

        // Back-to-back 8N1 frames
        send_frame(8'h01, 8, 0, 0, 0, 0, 0, 0, -1);
        check("b2b_first", 32'(data_o), 32'h01);
        send_frame(8'hFE, 8, 0, 0, 0, 0, 0, 0, -1);
        check("b2b_second", 32'(data_o), 32'hFE);

        // Break: line low for many bit times, exactly one frame with ferr
        begin
            exp_t e;
            e.data = 8'h00; e.perr = 1'b0; e.ferr = 1'b1;
            @(negedge clk);
            dbits = 2'd3; pen = 1'b0; ptype = 1'b0; stop2 = 1'b0;
            q.push_back(e);
            rx = 1'b0;
            wait_ticks(14 * OS);
            idle_bits(2);
            check("break_drained", 32'(q.size()), 0);
            check("break_ferr", 32'(frame_err_o), 1);
            check("break_data", 32'(data_o), 0);
        end

        // Random frames with random gaps
        for (int k = 0; k < 30; k++) begin
            int   n;
            int   gap;
            logic s2;
            logic s1l;
            logic s2l;
            n   = 5 + int'($urandom_range(0, 3));
            s2  = 1'($urandom);
            s1l = ($urandom_range(0, 5) == 0);
            s2l = ($urandom_range(0, 5) == 0);
            send_frame(8'($urandom), n, 1'($urandom), 1'($urandom), s2,
                       ($urandom_range(0, 3) == 0), s1l, s2l, -1);
            gap = int'($urandom_range(0, 2));
            if ((s2 ? s2l : s1l) && gap == 0) gap = 1;
            if (gap > 0) idle_bits(gap);
        end
        idle_bits(1);
        check("final_drained", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
